// File: rtl/vga_fb_arbiter_pkg.sv
// Shared timing constants and helpers for the VGA framebuffer arbiter.
// Row base address is built from shifts so no multiplier is inferred.
package vga_fb_arbiter_pkg;

    localparam int H_ACT          = 640;
    localparam int H_TOTAL        = 800;
    localparam int V_ACT          = 480;
    localparam int V_TOTAL        = 525;
    localparam int WORDS_PER_LINE = H_ACT / 4;
    localparam int FB_WORDS       = 19200;

    // Last in-line prefetch column, and the column that fetches the next row.
    localparam int SLOT_X_END  = 4 * (WORDS_PER_LINE - 1);
    localparam int ROW_FETCH_X = H_TOTAL - 4;

    localparam int ROW_W = 17;

    // y*160 as (y<<7)+(y<<5)
    function automatic logic [ROW_W-1:0] row_base(input logic [9:0] row);
        logic [ROW_W-1:0] r;
        r = ROW_W'(row);
        return (r << 7) + (r << 5);
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_fifo.sv
// fb_wr_fifo: small write queue holding {address, word} entries.
// Pushes are ignored when full, pops are ignored when empty.
module fb_wr_fifo #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Entry storage; no reset needed since count guards every read.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers and occupancy; push+pop together leaves count unchanged.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between
// beam-ahead scan-out prefetch and a queued pixel writer.
module vga_fb_arbiter #(
    parameter int PIX_W      = 4,
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [9:0]           x,
    input  logic [9:0]           y,
    input  logic                 video,
    output logic [PIX_W-1:0]     pix_out,
    output logic                 pix_valid,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [4*PIX_W-1:0]   wr_data,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_we,
    output logic [4*PIX_W-1:0]   mem_wdata,
    input  logic [4*PIX_W-1:0]   mem_rdata
);

    import vga_fb_arbiter_pkg::*;

    localparam int WORD_W = 4 * PIX_W;
    localparam int ENT_W  = ADDR_W + WORD_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [9:0]        next_row;
    logic              slot_pix;
    logic              slot_row;
    logic              slot;
    logic [ROW_W-1:0]  pix_word;
    logic [ROW_W-1:0]  row_word;
    logic [ADDR_W-1:0] scan_addr;
    logic [ENT_W-1:0]  head;
    logic [ADDR_W-1:0] head_addr;
    logic [WORD_W-1:0] head_data;
    logic              head_ok;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [CNT_W-1:0]  fifo_count;
    logic              rd_pend;
    logic [WORD_W-1:0] cur;
    logic [WORD_W-1:0] nxt;
    logic [PIX_W-1:0]  pix_sel;

    // Slot decode: in-line prefetch one word ahead, or row start at x=796.
    assign next_row = (y == 10'(V_TOTAL - 1)) ? 10'd0 : y + 10'd1;
    assign slot_pix = video && (x[1:0] == 2'd0) && (x < 10'(SLOT_X_END));
    assign slot_row = (x == 10'(ROW_FETCH_X)) && (next_row < 10'(V_ACT));
    assign slot     = slot_pix | slot_row;

    assign pix_word  = row_base(y) + ROW_W'(x[9:2]) + ROW_W'(1);
    assign row_word  = row_base(next_row);
    assign scan_addr = slot_pix ? ADDR_W'(pix_word) : ADDR_W'(row_word);

    fb_wr_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (wr_valid),
        .push_data ({wr_addr, wr_data}),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign {head_addr, head_data} = head;
    assign head_ok  = 32'(head_addr) < 32'(FB_WORDS);
    assign wr_ready = ~fifo_full;

    // Any cycle the beam does not need drains the queue head.
    assign fifo_pop  = ~slot & ~fifo_empty;
    assign mem_we    = fifo_pop & head_ok;
    assign mem_addr  = mem_we ? head_addr : (slot ? scan_addr : '0);
    assign mem_wdata = mem_we ? head_data : '0;

    assert property (@(posedge clock) disable iff (!reset_n)
        fifo_empty == (fifo_count == '0));

    // Flag the cycle after a slot, when RAM read data is valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rd_pend <= 1'b0;
        else          rd_pend <= slot;
    end

    // nxt catches the prefetched word; cur takes it at each word boundary.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            nxt <= '0;
            cur <= '0;
        end else begin
            if (rd_pend)          nxt <= mem_rdata;
            if (x[1:0] == 2'd3)   cur <= nxt;
        end
    end

    assign pix_sel = cur[PIX_W * x[1:0] +: PIX_W];

    // Registered pixel select gives exactly one cycle of latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pix_out   <= '0;
            pix_valid <= 1'b0;
        end else begin
            pix_out   <= video ? pix_sel : '0;
            pix_valid <= video;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter: acts as controlador and the RAM,
// and predicts RAM traffic and pixels from a queue/word-level model.
module tb_vga_fb_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        video;
    logic [3:0]  pix_out;
    logic        pix_valid;
    logic        wr_valid;
    logic        wr_ready;
    logic [14:0] wr_addr;
    logic [15:0] wr_data;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    vga_fb_arbiter dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .x         (x),
        .y         (y),
        .video     (video),
        .pix_out   (pix_out),
        .pix_valid (pix_valid),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] init_word(input int a);
        logic [31:0] t;
        t = 32'(a) * 32'd40503 + 32'h5A5A;
        return t[15:0];
    endfunction

    // Synchronous single-port RAM, read data one cycle after address.
    logic [15:0] ram [int];
    always @(posedge clock) begin
        logic [15:0] rd;
        rd = ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)]
                                        : init_word(int'(mem_addr));
        if (mem_we) ram[int'(mem_addr)] = mem_wdata;
        mem_rdata <= rd;
    end

    // Reference model state
    typedef struct {
        int          a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        int          x;
        int          y;
        bit          inrst;
        bit          slot;
        bit          acc;
        bit          achk;
        bit          pknown;
        logic [3:0]  pix;
        logic [3:0]  epix;
        logic        pv;
        logic        epv;
        logic        we;
        logic        ewe;
        logic        rdy;
        logic        erdy;
        logic [14:0] addr;
        logic [14:0] eaddr;
        logic [15:0] wdata;
        logic [15:0] ewdata;
    } step_t;

    wr_t         q[$];
    logic [15:0] shadow [int];
    logic [15:0] fetched [int];
    int          bx = 0;
    int          by = 0;
    logic [3:0]  nx_pix = '0;
    logic        nx_pv = 1'b0;
    bit          nx_known = 1'b0;

    function automatic logic [15:0] rd_shadow(input int a);
        return shadow.exists(a) ? shadow[a] : init_word(a);
    endfunction

    task automatic set_beam(input int row, input int col);
        by = row;
        bx = col;
    endtask

    // One pixel clock: sample registered outputs, drive, predict.
    task automatic tick(input bit rst, input bit push, input int a,
                        input logic [15:0] d, output step_t s);
        int          nrow;
        int          w;
        bit          vis;
        bit          sa;
        bit          sb;
        wr_t         e;
        logic [15:0] word;
        @(negedge clock);
        s = '{default: 0};
        s.pix    = pix_out;
        s.pv     = pix_valid;
        s.epix   = nx_pix;
        s.epv    = nx_pv;
        s.pknown = nx_known;
        vis      = (bx < 640) && (by < 480);
        reset_n  = !rst;
        x        = 10'(bx);
        y        = 10'(by);
        video    = vis;
        wr_valid = push;
        wr_addr  = 15'(a);
        wr_data  = d;
        #1;
        s.x     = bx;
        s.y     = by;
        s.inrst = rst;
        s.rdy   = wr_ready;
        s.we    = mem_we;
        s.addr  = mem_addr;
        s.wdata = mem_wdata;
        s.erdy  = 1'b1;
        s.ewe   = 1'b0;
        if (rst) begin
            q.delete();
            fetched.delete();
            nx_pix   = '0;
            nx_pv    = 1'b0;
            nx_known = 1'b1;
        end else begin
            nrow   = (by == 524) ? 0 : by + 1;
            sa     = vis && (bx % 4 == 0) && (bx < 636);
            sb     = (bx == 796) && (nrow < 480);
            s.slot = sa || sb;
            s.erdy = q.size() < 4;
            s.acc  = push && s.erdy;
            if (s.slot) begin
                s.eaddr = 15'(sa ? by * 160 + bx / 4 + 1 : nrow * 160);
                s.achk  = 1'b1;
                fetched[int'(s.eaddr)] = rd_shadow(int'(s.eaddr));
            end else if (q.size() != 0) begin
                e        = q.pop_front();
                s.ewe    = e.a < 19200;
                s.achk   = s.ewe;
                s.eaddr  = 15'(e.a);
                s.ewdata = e.d;
                if (s.ewe) shadow[e.a] = e.d;
            end else begin
                s.achk  = 1'b1;
                s.eaddr = '0;
            end
            if (s.acc) q.push_back('{a, d});
            if (vis) begin
                w        = (by * 160 + bx / 4) % 32768;
                nx_known = fetched.exists(w);
                word     = nx_known ? fetched[w] : 16'h0;
                nx_pix   = word[4 * (bx % 4) +: 4];
                nx_pv    = 1'b1;
            end else begin
                nx_known = 1'b1;
                nx_pix   = '0;
                nx_pv    = 1'b0;
            end
        end
        bx++;
        if (bx == 800) begin
            bx = 0;
            by = (by == 524) ? 0 : by + 1;
        end
    endtask

    task automatic test_reset();
        step_t s;
        set_beam(3, 100);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1, 40, 16'h1111, s);
            checks++;
            if (s.rdy !== 1'b1 || s.we !== 1'b0) begin
                errors++;
                $display("FAIL reset_mem got rdy=%b we=%b want 1/0", s.rdy, s.we);
            end
            if (i > 0) begin
                checks++;
                if (s.pix !== 4'h0 || s.pv !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_pix got %h/%b want 0/0", s.pix, s.pv);
                end
            end
        end
        tick(1'b0, 1'b0, 0, '0, s);
        tick(1'b0, 1'b0, 0, '0, s);
        checks++;
        if (s.pix !== 4'h0 || s.pv !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_pix got %h/%b want 0/1", s.pix, s.pv);
        end
        set_beam(2, 790);
        for (int i = 0; i < 420; i++) begin
            tick(1'b0, 1'b0, 0, '0, s);
            checks++;
            if (s.pknown && (s.pix !== s.epix || s.pv !== s.epv)) begin
                errors++;
                $display("FAIL reset_run_pix y=%0d x=%0d got %h/%b want %h/%b",
                         s.y, s.x, s.pix, s.pv, s.epix, s.epv);
            end
        end
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 41, 16'h2222, s);
        tick(1'b0, 1'b0, 0, '0, s);
        tick(1'b0, 1'b0, 0, '0, s);
        checks++;
        if (s.we !== 1'b0 || s.rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_push got we=%b rdy=%b want 0/1", s.we, s.rdy);
        end
    endtask

    task automatic test_scan();
        step_t s;
        set_beam(500, 0);
        tick(1'b0, 1'b1, 0, 16'h3210, s);
        tick(1'b0, 1'b1, 1, 16'h7654, s);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 0, '0, s);
        set_beam(524, 790);
        for (int i = 0; i < 60; i++) begin
            tick(1'b0, 1'b0, 0, '0, s);
            checks++;
            if (s.we !== s.ewe || s.rdy !== s.erdy
                || (s.achk && s.addr !== s.eaddr)) begin
                errors++;
                $display("FAIL scan_mem y=%0d x=%0d got we=%b a=%0d want we=%b a=%0d",
                         s.y, s.x, s.we, s.addr, s.ewe, s.eaddr);
            end
            if (s.pknown) begin
                checks++;
                if (s.pix !== s.epix || s.pv !== s.epv) begin
                    errors++;
                    $display("FAIL scan_pix y=%0d x=%0d got %h/%b want %h/%b",
                             s.y, s.x, s.pix, s.pv, s.epix, s.epv);
                end
            end
            if (s.y == 524 && s.x == 796) begin
                checks++;
                if (s.addr !== 15'd0 || s.we !== 1'b0) begin
                    errors++;
                    $display("FAIL scan_row_fetch got a=%0d we=%b want 0/0", s.addr, s.we);
                end
            end
            if (s.y == 0 && s.x == 0) begin
                checks++;
                if (s.addr !== 15'd1) begin
                    errors++;
                    $display("FAIL scan_ahead got a=%0d want 1", s.addr);
                end
            end
            if (s.y == 0 && s.x >= 1 && s.x <= 8) begin
                checks++;
                if (s.pix !== 4'(s.x - 1) || s.pv !== 1'b1) begin
                    errors++;
                    $display("FAIL scan_pix_seq x=%0d got %h/%b want %h/1",
                             s.x - 1, s.pix, s.pv, 4'(s.x - 1));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t s;
        set_beam(9, 790);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 0, '0, s);
        for (int i = 0; i < 45; i++) begin
            if (i < 5) tick(1'b0, 1'b1, 3000 + i, 16'($urandom), s);
            else       tick(1'b0, 1'b0, 0, '0, s);
            checks++;
            if (s.we !== s.ewe || s.rdy !== s.erdy
                || (s.achk && s.addr !== s.eaddr)
                || (s.ewe && s.wdata !== s.ewdata)) begin
                errors++;
                $display("FAIL b2b_mem x=%0d got we=%b a=%0d d=%h r=%b want %b/%0d/%h/%b",
                         s.x, s.we, s.addr, s.wdata, s.rdy,
                         s.ewe, s.eaddr, s.ewdata, s.erdy);
            end
            if (s.y == 10 && s.x % 4 == 0 && s.x < 636) begin
                checks++;
                if (s.we !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_slot_write x=%0d got we=%b want 0", s.x, s.we);
                end
            end
        end
    endtask

    task automatic test_drain();
        step_t       s;
        int          ea [4];
        logic [15:0] ed [4];
        set_beam(500, 100);
        for (int i = 0; i < 4; i++) begin
            ea[i] = $urandom_range(0, 19199);
            ed[i] = 16'($urandom);
        end
        for (int i = 0; i < 6; i++) begin
            if (i < 4) tick(1'b0, 1'b1, ea[i], ed[i], s);
            else       tick(1'b0, 1'b0, 0, '0, s);
            if (i >= 1 && i <= 4) begin
                checks++;
                if (s.we !== 1'b1 || s.addr !== 15'(ea[i-1])
                    || s.wdata !== ed[i-1]) begin
                    errors++;
                    $display("FAIL drain_order n=%0d got we=%b a=%0d d=%h want 1/%0d/%h",
                             i - 1, s.we, s.addr, s.wdata, ea[i-1], ed[i-1]);
                end
            end else begin
                checks++;
                if (s.we !== 1'b0 || s.rdy !== 1'b1) begin
                    errors++;
                    $display("FAIL drain_idle n=%0d got we=%b rdy=%b want 0/1",
                             i, s.we, s.rdy);
                end
            end
        end
    endtask

    task automatic test_drop();
        step_t s;
        set_beam(500, 200);
        tick(1'b0, 1'b1, 19200, 16'hDEAD, s);
        tick(1'b0, 1'b1, 300, 16'hBEEF, s);
        checks++;
        if (s.we !== 1'b0 || s.rdy !== 1'b1) begin
            errors++;
            $display("FAIL drop_19200 got we=%b rdy=%b want 0/1", s.we, s.rdy);
        end
        tick(1'b0, 1'b1, 32767, 16'hF00D, s);
        checks++;
        if (s.we !== 1'b1 || s.addr !== 15'd300 || s.wdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL drop_next got we=%b a=%0d d=%h want 1/300/beef",
                     s.we, s.addr, s.wdata);
        end
        tick(1'b0, 1'b0, 0, '0, s);
        checks++;
        if (s.we !== 1'b0) begin
            errors++;
            $display("FAIL drop_32767 got we=%b want 0", s.we);
        end
        tick(1'b0, 1'b0, 0, '0, s);
        checks++;
        if (ram.exists(19200) || ram.exists(32767)) begin
            errors++;
            $display("FAIL drop_ram got written=1 want 0");
        end
    endtask

    task automatic test_vblank_write();
        step_t s;
        set_beam(500, 300);
        tick(1'b0, 1'b1, 162, 16'hAAAA, s);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 0, '0, s);
        set_beam(0, 790);
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b0, 0, '0, s);
            if (s.pknown) begin
                checks++;
                if (s.pix !== s.epix || s.pv !== s.epv) begin
                    errors++;
                    $display("FAIL vbw_pix y=%0d x=%0d got %h/%b want %h/%b",
                             s.y, s.x, s.pix, s.pv, s.epix, s.epv);
                end
            end
            if (s.y == 1 && s.x >= 9 && s.x <= 12) begin
                checks++;
                if (s.pix !== 4'hA || s.pv !== 1'b1) begin
                    errors++;
                    $display("FAIL vbw_A x=%0d got %h/%b want a/1", s.x - 1, s.pix, s.pv);
                end
            end
        end
    endtask

    task automatic test_random();
        step_t s;
        bit    p;
        int    a;
        int    bad;
        set_beam(1, 790);
        for (int i = 0; i < 3300; i++) begin
            p = ($urandom_range(0, 2) == 0);
            a = $urandom_range(0, 19299);
            tick(1'b0, p, a, 16'($urandom), s);
            checks++;
            if (s.we !== s.ewe || s.rdy !== s.erdy
                || (s.achk && s.addr !== s.eaddr)
                || (s.ewe && s.wdata !== s.ewdata)) begin
                errors++;
                $display("FAIL rnd_mem y=%0d x=%0d got we=%b a=%0d d=%h want %b/%0d/%h",
                         s.y, s.x, s.we, s.addr, s.wdata, s.ewe, s.eaddr, s.ewdata);
            end
            if (s.pknown) begin
                checks++;
                if (s.pix !== s.epix || s.pv !== s.epv) begin
                    errors++;
                    $display("FAIL rnd_pix y=%0d x=%0d got %h/%b want %h/%b",
                             s.y, s.x, s.pix, s.pv, s.epix, s.epv);
                end
            end
        end
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 0, '0, s);
        bad = 0;
        foreach (shadow[k]) begin
            if (!ram.exists(k) || ram[k] !== shadow[k]) bad++;
        end
        foreach (ram[k]) begin
            if (k >= 19200) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rnd_ram_contents got %0d bad words want 0", bad);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        x        = '0;
        y        = '0;
        video    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        test_reset();
        test_scan();
        test_back_to_back();
        test_drain();
        test_drop();
        test_vblank_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
